input_debouncer: RTL and testbench
==================================

# input_debouncer

Synchronizes and debounces the raw single-bit input `A` and delivers a clean, glitch-free level `Y`. It sits directly upstream of the registered NOT stage (`notmodule`) and drives that stage's `A` input. It provides:
- a 2-flop synchronizer;
- a 4-state debounce FSM with a stability counter;
- optional rise/fall strobes for downstream edge-triggered logic.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before `Y` follows. Legal range is 2..255.
- `CNT_W`, default 3: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES-1.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset`=0 resets on the next rising edge of `clock`).
- `A`  in  1  raw, asynchronous, possibly bouncing input.
- `Y`  out  1  debounced level, registered; feeds `notmodule.A`.
- `busy`  out  1  high while a candidate level change is being qualified.
- `rise`  out  1  one-cycle strobe on the `Y` 0->1 change (only when `DEBOUNCE_EDGE_EN` is defined).
- `fall`  out  1  one-cycle strobe on the `Y` 1->0 change (only when `DEBOUNCE_EDGE_EN` is defined).

## Operation
- Synchronizer: `s1 <= A; s2 <= s1`. The FSM only looks at `s2`.
- FSM states are `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`. In `IDLE_LOW`/`WAIT_HIGH` `Y`=0; in `IDLE_HIGH`/`WAIT_LOW` `Y`=1.
- `IDLE_LOW`:
  - `s2`=1 -> go to `WAIT_HIGH` with `cnt<=1`.
  - otherwise stay.
- `WAIT_HIGH`:
  - `s2`=0 -> go to `IDLE_LOW` with `cnt<=0` (glitch rejected, `Y` unchanged).
  - else `cnt`==STABLE_CYCLES-1 -> go to `IDLE_HIGH` with `Y<=1`, `rise<=1` and `cnt<=0`.
  - else `cnt<=cnt+1`.
- `IDLE_HIGH` and `WAIT_LOW` mirror the above with polarity inverted. The `WAIT_LOW` -> `IDLE_LOW` transition drives `Y<=0` and `fall<=1`.
- `busy` is 1 exactly in `WAIT_HIGH`/`WAIT_LOW`. It is registered, i.e. decoded from the state register.
- `rise`/`fall`:
  - Registered and asserted for exactly one cycle, in the same cycle `Y` changes.
  - Never both 1 at once.
  - Deasserted the following cycle unconditionally.
- Counter: unsigned, `CNT_W` bits. It never exceeds STABLE_CYCLES-1 and never wraps, because the transition fires first.
- A bounce in `s2` during a WAIT state restarts qualification from zero. Any bounce shorter than STABLE_CYCLES synchronized cycles never reaches `Y`.

## Timing
- Reset values (`reset`=0 at a rising edge):
  - `s1`=`s2`=0, state=`IDLE_LOW`, `cnt`=0;
  - `Y`=0, `busy`=0, `rise`=0, `fall`=0.
  - Reset has priority over every other condition.
- Reset mid-qualification abandons the pending change. The first state after reset release is `IDLE_LOW`, regardless of `A`.
- If `A` is 1 at reset release, `Y` rises STABLE_CYCLES+2 cycles after release, through the normal path.
- Latency: `A` stable from before edge N gives:
  - `s2` valid after edge N+1;
  - `busy`=1 after edge N+2;
  - `Y` (and its strobe) change after edge N+STABLE_CYCLES+1.
  - With the default, `Y` changes after edge N+5, and `busy` is 1 after edges N+2..N+4.
- `A` returning to the old level exactly on the qualifying edge (i.e. `s2` drops at that edge): the glitch branch wins and `Y` does not change.
- Throughput: back-to-back opposite changes are allowed. `IDLE_HIGH` can enter `WAIT_LOW` on the cycle right after `rise`.

## Configuration
- Macro `DEBOUNCE_EDGE_EN`.
- Defined:
  - `rise`/`fall` ports exist;
  - their registers are implemented as above.
- Undefined:
  - `rise`/`fall` ports and registers are compiled out;
  - `Y`, `busy` and all timing are identical to the defined build.
- The bench guards strobe checks with the same macro.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: hold `reset`=0 for 3 cycles with `A`=1 -> `Y`=0, `busy`=0, `rise`=`fall`=0 throughout. After release, `Y`=1 6 cycles later.
- Clean rise: `A` 0->1 before edge 10 and held -> `busy`=1 after edges 12..14. `Y`=1 and `rise`=1 after edge 15. `rise`=0 after edge 16.
- Glitch rejection: `A`=1 for 3 cycles, then 0 -> `Y` stays 0, `busy` pulses for 3 cycles then returns to 0, `rise` never asserts.
- Bounce-then-settle: `A` toggles 1,0,1,0,1 at single-cycle spacing, then holds 1 -> `Y` rises exactly 6 cycles after the final 0->1. A single `rise` pulse.
- Clean fall: from `Y`=1, `A` 1->0 before edge 30 -> `Y`=0 and `fall`=1 after edge 35. `rise` stays 0.
- Reset mid-qualification: assert `reset`=0 while `busy`=1 in `WAIT_HIGH` -> next cycle state is `IDLE_LOW`, `Y`=0, `busy`=0. No strobe is emitted.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus four-state debounce FSM for one raw input.
// Defining DEBOUNCE_EDGE_EN adds the registered rise/fall strobe ports.
module input_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic A,
   output logic Y,
   output logic busy
`ifdef DEBOUNCE_EDGE_EN
   ,
   output logic rise,
   output logic fall
`endif
);

   // bit0 is the debounced level and bit1 marks qualification, so Y and busy are plain flop outputs
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      IDLE_HIGH = 2'b01,
      WAIT_HIGH = 2'b10,
      WAIT_LOW  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q;
   logic             s2_q;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE_LOW;
         cnt_q   <= CNT_ZERO;
      end else begin
         s1_q    <= A;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_LOW: begin
            if (s2_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = IDLE_LOW;
               cnt_d   = cnt_q;
            end
         end
         WAIT_HIGH: begin
            if (!s2_q) begin
               state_d = IDLE_LOW;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = WAIT_HIGH;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s2_q) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = IDLE_HIGH;
               cnt_d   = cnt_q;
            end
         end
         WAIT_LOW: begin
            if (s2_q) begin
               state_d = IDLE_HIGH;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = WAIT_LOW;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   always_comb begin
      Y    = state_q[0];
      busy = state_q[1];
   end

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q;
   logic rise_d;
   logic fall_q;
   logic fall_d;

   // Strobes fire only on the qualifying transitions out of a WAIT state
   always_comb begin
      rise_d = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
      fall_d = (state_q == WAIT_LOW)  && (state_d == IDLE_LOW);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   always_comb begin
      rise = rise_q;
      fall = fall_q;
   end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: directed scenarios then random bouncing input.
// Strobe checks are enabled only when DEBOUNCE_EDGE_EN is defined.
module tb_input_debouncer;
   localparam int STABLE = 4;

   logic clock;
   logic reset;
   logic A;
   logic Y;
   logic busy;
   logic rise;
   logic fall;

   int n_checks;
   int n_pass;
   logic [3:0] expq[$];

   // reference model state: synchronizer samples, level, run of disagreeing samples
   logic m_s1, m_s2, m_y, m_rise, m_fall;
   int   m_run;

`ifdef DEBOUNCE_EDGE_EN
   localparam logic [3:0] CMP_MASK = 4'b1111;
   input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .A(A), .Y(Y), .busy(busy), .rise(rise), .fall(fall)
   );
`else
   localparam logic [3:0] CMP_MASK = 4'b1100;
   assign rise = 1'b0;
   assign fall = 1'b0;
   input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .A(A), .Y(Y), .busy(busy)
   );
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock edge: apply inputs, then advance the model and queue the expectation
   task automatic step(input logic a, input logic r);
      logic seen;
      A     = a;
      reset = r;
      @(posedge clock);
      if (!r) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_y = 1'b0; m_run = 0;
         m_rise = 1'b0; m_fall = 1'b0;
      end else begin
         seen   = m_s2;
         m_s2   = m_s1;
         m_s1   = a;
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (seen != m_y) m_run = m_run + 1;
         else m_run = 0;
         if (m_run == STABLE) begin
            m_y    = ~m_y;
            m_rise = m_y;
            m_fall = ~m_y;
            m_run  = 0;
         end
      end
      expq.push_back({m_y, (m_run != 0), m_rise, m_fall});
      #1;
   endtask

   task automatic hold(input logic a, input int n);
      for (int i = 0; i < n; i++) step(a, 1'b1);
   endtask

   // Monitor: every falling edge the DUT presents an output word to score
   initial begin
      logic [3:0] exp_v;
      logic [3:0] act_v;
      forever begin
         @(negedge clock);
         if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            act_v = {Y, busy, rise, fall};
            n_checks = n_checks + 1;
            if ((act_v & CMP_MASK) === (exp_v & CMP_MASK)) n_pass = n_pass + 1;
            else $display("FAIL outputs t=%0t got Y/busy/rise/fall=%b required %b (mask %b)",
                          $time, act_v, exp_v, CMP_MASK);
         end
      end
   end

   initial begin
      int seg;
      logic lvl;
      n_checks = 0;
      n_pass   = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_y = 1'b0; m_run = 0; m_rise = 1'b0; m_fall = 1'b0;
      A     = 1'b0;
      reset = 1'b0;

      // reset held with A high, then rise through the normal path
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      hold(1'b1, 8);
      // clean fall, clean rise
      hold(1'b0, 8);
      hold(1'b1, 8);
      hold(1'b0, 8);
      // glitch rejection
      hold(1'b1, 3);
      hold(1'b0, 8);
      // bounce then settle
      hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
      hold(1'b1, 9);
      // back-to-back opposite change right after the strobe
      hold(1'b0, 4);
      hold(1'b1, 9);
      // reset during qualification
      hold(1'b0, 3);
      step(1'b0, 1'b0);
      hold(1'b0, 8);
      hold(1'b1, 3);
      step(1'b1, 1'b0);
      hold(1'b0, 6);

      // random bouncing segments with occasional resets
      lvl = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 39) == 0) begin
            step(1'($urandom_range(0, 1)), 1'b0);
         end else begin
            lvl = ~lvl;
            seg = $urandom_range(1, 7);
            hold(lvl, seg);
         end
      end
      hold(lvl, 8);

      @(negedge clock);
      #1;
      n_checks = n_checks + 1;
      if (expq.size() == 0) n_pass = n_pass + 1;
      else $display("FAIL drain got %0d pending required 0", expq.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
